demux_rr_feeder: RTL and testbench

Upstream feeder for the 1:4 demux (demux_1_4). Accepts a serial bit stream over a valid/ready handshake and drives the demux select lines and data input. Bits are distributed round-robin across four channels in bursts of BURST bits, and channels that are not ready are skipped. Also keeps per-channel bit counters and a stall counter for debug.

---
 rtl/demux_rr_feeder.sv | 105 ++++++++++
 tb/tb_demux_rr_feeder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/demux_rr_feeder.sv
// Round-robin feeder for a 1:4 demux: spreads a serial bit stream over
// four channels in bursts, skipping channels that are not ready.
module demux_rr_feeder #(
  parameter int BURST = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             in_ready,
  input  logic [3:0]       ch_ready,
  output logic             sel0,
  output logic             sel1,
  output logic             i,
  output logic             out_valid,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] ONE = 1;
  localparam logic [7:0] LAST = 8'(BURST - 1);

  state_t           state, state_nx;
  logic [1:0]       ptr, target, idx;
  logic [7:0]       burst_cnt;
  logic             found, xfer;
  logic [CNT_W-1:0] cnt [4];

  assign in_ready  = rst_n & (|ch_ready);
  assign xfer      = in_valid & in_ready;
  assign out_valid = (state == RUN);
  assign cnt0      = cnt[0];
  assign cnt1      = cnt[1];
  assign cnt2      = cnt[2];
  assign cnt3      = cnt[3];

  // first ready channel at or after ptr, wrapping
  always_comb begin
    target = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && ch_ready[idx]) begin
        target = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    if (xfer) state_nx = RUN;
    else      state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel0      <= 1'b0;
      sel1      <= 1'b0;
      i         <= 1'b0;
      ptr       <= 2'd0;
      burst_cnt <= 8'd0;
      stall_cnt <= '0;
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
    end else begin
      if (xfer) begin
        {sel0, sel1} <= target;
        i            <= in_bit;
        cnt[target]  <= cnt[target] + ONE;
        if (target == ptr) begin
          if (burst_cnt == LAST) begin
            burst_cnt <= 8'd0;
            ptr       <= ptr + 2'd1;
          end else begin
            burst_cnt <= burst_cnt + 8'd1;
          end
        end else if (BURST == 1) begin
          ptr       <= target + 2'd1;
          burst_cnt <= 8'd0;
        end else begin
          // skipped channels abandon the partial burst
          ptr       <= target;
          burst_cnt <= 8'd1;
        end
      end else begin
        i <= 1'b0;
      end
      if (in_valid && !in_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + ONE;
    end
  end

endmodule

// File: tb/tb_demux_rr_feeder.sv
// Scoreboard bench: two feeders (BURST=1 and BURST=3) share one
// random/directed stimulus stream and are checked against a queue model.
module tb_demux_rr_feeder;

  localparam int B0 = 1;
  localparam int B1 = 3;

  logic       clk = 0;
  logic       rst_n = 0;
  logic       in_valid = 0;
  logic       in_bit = 0;
  logic [3:0] ch_ready = 0;

  logic [1:0]           in_ready_o, sel0_o, sel1_o, i_o, ov_o;
  logic [1:0][3:0][7:0] cnt_o;
  logic [1:0][7:0]      stall_o;

  int errors = 0;
  int checks = 0;

  int m_ptr [2];
  int m_bc  [2];
  int m_cnt [2][4];
  int m_stall;
  int q [2][$];
  bit done = 0;

  always #5 clk = ~clk;

  demux_rr_feeder #(.BURST(B0), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready_o[0]), .ch_ready(ch_ready),
    .sel0(sel0_o[0]), .sel1(sel1_o[0]), .i(i_o[0]), .out_valid(ov_o[0]),
    .cnt0(cnt_o[0][0]), .cnt1(cnt_o[0][1]),
    .cnt2(cnt_o[0][2]), .cnt3(cnt_o[0][3]),
    .stall_cnt(stall_o[0])
  );

  demux_rr_feeder #(.BURST(B1), .CNT_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit),
    .in_ready(in_ready_o[1]), .ch_ready(ch_ready),
    .sel0(sel0_o[1]), .sel1(sel1_o[1]), .i(i_o[1]), .out_valid(ov_o[1]),
    .cnt0(cnt_o[1][0]), .cnt1(cnt_o[1][1]),
    .cnt2(cnt_o[1][2]), .cnt3(cnt_o[1][3]),
    .stall_cnt(stall_o[1])
  );

  task automatic chk(input string name, input int k,
                     input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s dut%0d got=%0d exp=%0d t=%0t",
               name, k, got, exp, $time);
    end
  endtask

  // reference model: advances on every rising edge from the inputs
  always @(posedge clk) begin
    if (!rst_n) begin
      m_stall = 0;
      for (int k = 0; k < 2; k++) begin
        m_ptr[k] = 0;
        m_bc[k]  = 0;
        q[k].delete();
        for (int c = 0; c < 4; c++) m_cnt[k][c] = 0;
      end
    end else if (in_valid && ch_ready != 0) begin
      for (int k = 0; k < 2; k++) begin
        int t, burst;
        burst = (k == 0) ? B0 : B1;
        t = -1;
        for (int s = 0; s < 4; s++)
          if (t < 0 && ch_ready[(m_ptr[k] + s) % 4]) t = (m_ptr[k] + s) % 4;
        q[k].push_back(t * 2 + int'(in_bit));
        m_cnt[k][t] = (m_cnt[k][t] + 1) % 256;
        if (t == m_ptr[k]) begin
          m_bc[k]++;
          if (m_bc[k] == burst) begin
            m_bc[k] = 0;
            m_ptr[k] = (m_ptr[k] + 1) % 4;
          end
        end else if (burst == 1) begin
          m_ptr[k] = (t + 1) % 4;
          m_bc[k] = 0;
        end else begin
          m_ptr[k] = t;
          m_bc[k] = 1;
        end
      end
    end else if (in_valid && m_stall < 255) begin
      m_stall++;
    end
  end

  // monitor: samples on the falling edge
  always @(negedge clk) begin
    if (!done) begin
      for (int k = 0; k < 2; k++) begin
        chk("in_ready", k, int'(in_ready_o[k]),
            int'(rst_n && ch_ready != 0));
        if (q[k].size() > 0) begin
          int e;
          e = q[k].pop_front();
          chk("out_valid", k, int'(ov_o[k]), 1);
          chk("sel", k, int'({sel0_o[k], sel1_o[k]}), e / 2);
          chk("i", k, int'(i_o[k]), e % 2);
        end else begin
          chk("out_valid", k, int'(ov_o[k]), 0);
          chk("i_idle", k, int'(i_o[k]), 0);
        end
        for (int c = 0; c < 4; c++)
          chk($sformatf("cnt%0d", c), k, int'(cnt_o[k][c]), m_cnt[k][c]);
        chk("stall_cnt", k, int'(stall_o[k]), m_stall);
      end
    end
  end

  task automatic step(input logic v, input logic b, input logic [3:0] r);
    @(posedge clk);
    #2;
    in_valid = v;
    in_bit   = b;
    ch_ready = r;
  endtask

  initial begin
    logic [7:0] bits;
    bits = 8'b10110010;
    step(0, 0, 4'h0);
    step(0, 0, 4'h0);
    rst_n = 1;
    step(0, 0, 4'hf);
    // round robin over all channels
    for (int n = 0; n < 8; n++) step(1, bits[7-n], 4'hf);
    step(0, 0, 4'hf);
    // only ch1 and ch3 ready
    for (int n = 0; n < 4; n++) step(1, n[0], 4'b1010);
    step(0, 0, 4'hf);
    for (int n = 0; n < 7; n++) step(1, ~n[0], 4'hf);
    // ch1 drops mid-burst
    step(1, 1, 4'hf);
    for (int n = 0; n < 3; n++) step(1, n[1], 4'b1101);
    // nothing ready: stalls
    for (int n = 0; n < 5; n++) step(1, 1, 4'h0);
    step(1, 1, 4'b0100);
    step(0, 0, 4'hf);
    // reset mid-stream with a bit offered
    step(1, 1, 4'hf);
    step(1, 0, 4'hf);
    rst_n = 0;
    step(1, 1, 4'hf);
    rst_n = 1;
    step(1, 1, 4'hf);
    step(1, 0, 4'hf);
    step(0, 0, 4'hf);
    // random traffic, occasional reset
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] r;
      r = 4'($urandom);
      if ($urandom_range(0, 3) == 0) r = 4'hf;
      if ($urandom_range(0, 19) == 0) r = 4'h0;
      rst_n = ($urandom_range(0, 599) != 0);
      step($urandom_range(0, 3) != 0, 1'($urandom), r);
    end
    rst_n = 1;
    // long stall to reach saturation
    for (int n = 0; n < 270; n++) step(1, 0, 4'h0);
    step(1, 1, 4'b1000);
    step(0, 0, 4'hf);
    step(0, 0, 4'hf);
    @(posedge clk);
    #2;
    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
